// File: rtl/sl_module_if.sv
// sl_module_if
//   Bundles the operand, the five stage selects and the registered result
//   of the 32-bit left barrel shifter.
//   Modports:
//     master : drives inp/select1..select5, observes outfifth
//     slave  : the shifter; consumes inp/selects, drives outfifth
interface sl_module_if;
  logic [31:0] inp;
  logic        select1;
  logic        select2;
  logic        select3;
  logic        select4;
  logic        select5;
  logic [31:0] outfifth;

  modport master (
    output inp, select1, select2, select3, select4, select5,
    input  outfifth
  );

  modport slave (
    input  inp, select1, select2, select3, select4, select5,
    output outfifth
  );
endinterface

// File: rtl/sl_module.sv
// sl_module
//   32-bit logical left barrel shifter. Five cascaded mux stages shift by
//   1, 2, 4, 8 and 16 under control of select1..select5, giving a total
//   shift of 0..31 with zero fill. Bits pushed past bit 31 are dropped.
//   The last stage is registered; the register loads every cycle.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset, clears outfifth at once
//     bus    : sl_module_if.slave (inp, select1..5 in; outfifth out)
module sl_module (
  input  logic        clk,
  input  logic        rst_n,
  sl_module_if.slave  bus
);
  localparam int WIDTH  = 32;
  localparam int STAGES = 5;

  // Bit gi enables the stage that shifts by 2**gi.
  logic [STAGES-1:0] sel;
  assign sel = {bus.select5, bus.select4, bus.select3, bus.select2, bus.select1};

  // stage[0] is the raw operand, stage[STAGES] is the fully shifted value.
  logic [WIDTH-1:0] stage [0:STAGES];
  assign stage[0] = bus.inp;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      // Per-bit 2:1 mux between the pass value and the zero-filled shift.
      assign stage[gi+1] = sel[gi] ? {stage[gi][WIDTH-1-SH:0], {SH{1'b0}}}
                                   : stage[gi];
    end
  endgenerate

  logic [WIDTH-1:0] outfifth_d;
  logic [WIDTH-1:0] outfifth_q;

  assign outfifth_d = stage[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outfifth_q <= '0;
    end else begin
      outfifth_q <= outfifth_d;
    end
  end

  assign bus.outfifth = outfifth_q;
endmodule

// File: tb/tb_sl_module.sv
// tb_sl_module
//   Self-checking bench for sl_module: reset behaviour, a table of directed
//   shift vectors with hand-computed results, and a random stream with a
//   mid-stream asynchronous reset pulse.
module tb_sl_module;
  logic clk;
  logic rst_n;

  sl_module_if bus ();

  sl_module u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] inp;
    logic [4:0]  sel;   // bit0 = select1 ... bit4 = select5
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic drive(input logic [31:0] d, input logic [4:0] s);
    bus.inp     = d;
    bus.select1 = s[0];
    bus.select2 = s[1];
    bus.select3 = s[2];
    bus.select4 = s[3];
    bus.select5 = s[4];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference: multiply by 2**N and keep the low 32 bits.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] prod;
    int n;
    n = (s[0] ? 1 : 0) + (s[1] ? 2 : 0) + (s[2] ? 4 : 0) + (s[3] ? 8 : 0) + (s[4] ? 16 : 0);
    prod = {32'd0, d} * (64'd1 << n);
    return prod[31:0];
  endfunction

  // Watchdog: the test is clock-bounded, this only guards a stalled sim.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_inp;
    logic [4:0]  r_sel;
    logic [31:0] r_exp;

    tests  = 0;
    errors = 0;

    vecs[0] = '{"T2_sel1",      32'hFFFF_FFF8, 5'b00001, 32'hFFFF_FFF0};
    vecs[1] = '{"T3_sel2",      32'hFFFF_FFF8, 5'b00010, 32'hFFFF_FFE0};
    vecs[2] = '{"T4_sel5",      32'h0000_FFFF, 5'b10000, 32'hFFFF_0000};
    vecs[3] = '{"T4_N9",        32'h0000_FFFF, 5'b01001, 32'h01FF_FE00};
    vecs[4] = '{"T5_all_sel",   32'h0000_0001, 5'b11111, 32'h8000_0000};
    vecs[5] = '{"T5_pass",      32'h1234_5678, 5'b00000, 32'h1234_5678};
    vecs[6] = '{"zero_in_N31",  32'h0000_0000, 5'b11111, 32'h0000_0000};
    vecs[7] = '{"msb_lost",     32'h8000_0001, 5'b00001, 32'h0000_0002};
    vecs[8] = '{"N21",          32'h0000_00FF, 5'b10101, 32'h1FE0_0000};
    vecs[9] = '{"N3",           32'h1234_5678, 5'b00011, 32'h91A2_B3C0};

    // T1: reset clears output with no clock edge, and holds through edges.
    rst_n = 1'b0;
    drive(32'hDEAD_BEEF, 5'b00000);
    #1;
    check("T1_reset_no_edge", bus.outfifth, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("T1_reset_held", bus.outfifth, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("T1_first_load", bus.outfifth, 32'hDEAD_BEEF);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].inp, vecs[i].sel);
      @(posedge clk);
      #1;
      check(vecs[i].name, bus.outfifth, vecs[i].exp);
    end

    // Load a nonzero value, then async reset between edges.
    drive(32'hCAFE_F00D, 5'b00000);
    @(posedge clk);
    #1;
    check("pre_async_reset", bus.outfifth, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", bus.outfifth, 32'h0);
    rst_n = 1'b1;

    // T6: random stream with one reset pulse in the middle.
    for (int i = 0; i < 1000; i++) begin
      r_inp = $urandom;
      r_sel = 5'($urandom_range(0, 31));
      r_exp = ref_shift(r_inp, r_sel);
      drive(r_inp, r_sel);
      if (i == 500) begin
        #2 rst_n = 1'b0;
        #1;
        check("T6_mid_reset_clear", bus.outfifth, 32'h0);
        @(posedge clk);
        #1;
        check("T6_reset_no_retain", bus.outfifth, 32'h0);
        rst_n = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        check($sformatf("T6_rand_%0d", i), bus.outfifth, r_exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
